sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
Single-clock, first-word-fall-through FIFO with valid/ready handshakes on both sides. The slave (write) side accepts data from an upstream producer. The master (read) side presents data to a downstream consumer. Status outputs report full, empty, and programmable almost-full/almost-empty levels. It is used as a generic rate-decoupling buffer between streaming blocks in one clock domain.

Parameters:
FIFO_DEPTH, 8, number of entries; power of two, at least 2.
DATA_WIDTH, 32, bit width of each data word.
WIDTH, 8, width of the almost-level threshold inputs; must satisfy 2^WIDTH > FIFO_DEPTH.

Ports:
i_clk  input  1  clock; all state updates on rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_valid_s  input  1  write request from upstream.
i_ready_m  input  1  downstream ready to accept o_dataout.
i_almostempty_lvl  input  WIDTH  almost-empty threshold, in entries.
i_almostfull_lvl  input  WIDTH  almost-full threshold, in entries.
i_datain  input  DATA_WIDTH  write data.
o_almostfull  output  1  high when count >= i_almostfull_lvl.
o_full  output  1  high when count == FIFO_DEPTH.
o_ready_s  output  1  FIFO can accept a write; equals !o_full.
o_valid_m  output  1  head entry valid; equals !o_empty.
o_almostempty  output  1  high when count <= i_almostempty_lvl.
o_empty  output  1  high when count == 0.
o_dataout  output  DATA_WIDTH  head-of-FIFO data.

Behaviour:
- State:
  - Storage array mem[FIFO_DEPTH].
  - Write pointer and read pointer, each clog2(FIFO_DEPTH) bits; they wrap naturally.
  - Occupancy counter count, clog2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
- Reset (i_rst_n low, asynchronous, takes effect immediately):
  - Pointers and count go to 0.
  - Outputs then read: o_empty=1, o_valid_m=0, o_full=0, o_ready_s=1, o_almostempty=1, o_dataout=0.
  - o_almostfull=1 only if i_almostfull_lvl==0.
  - Storage contents are not reset.
  - Reset asserted mid-operation discards all contents; no partial transfer completes.
- Write: on a rising edge with i_valid_s && o_ready_s:
  - mem[wr_ptr] <= i_datain.
  - wr_ptr increments modulo FIFO_DEPTH.
  - When full, i_valid_s is ignored and no state changes.
- Read: on a rising edge with o_valid_m && i_ready_m:
  - rd_ptr increments modulo FIFO_DEPTH.
  - When empty, i_ready_m is ignored.
- Count:
  - +1 on write only.
  - -1 on read only.
  - Unchanged when both occur or neither occurs.
- Simultaneous write and read:
  - Both take effect when allowed.
  - When full, o_ready_s=0 blocks the write even if a read happens in the same cycle; ready reasserts the next cycle.
  - When empty, only the write happens.
- First-word fall-through:
  - o_dataout = mem[rd_ptr] combinationally when !o_empty, else 0.
  - A word written into an empty FIFO appears on o_dataout with o_valid_m=1 one cycle after the write edge (latency 1).
  - o_dataout must hold stable while o_valid_m=1 and i_ready_m=0.
- Status flags:
  - All are combinational from the count register, so they update one edge after the causing transfer.
  - Almost-level comparisons are unsigned, with count zero-extended to WIDTH.
  - Threshold inputs may change at any time; the flags follow combinationally.

Decomposition:
- No shared package is needed.
- Pointer and count widths are local parameters derived with $clog2.
- One optional sub-module: sync_fifo_mem, a simple dual-port array with synchronous write and asynchronous read. Everything else stays inline.

Test Plan:
- Reset release with lvl_ae=2, lvl_af=5 -> o_empty=1, o_valid_m=0, o_ready_s=1, o_full=0, o_almostempty=1, o_almostfull=0, o_dataout=0.
- Write 5 random words back-to-back, i_ready_m=0:
  - After the 1st edge, o_valid_m=1 and o_dataout=word0.
  - o_almostempty drops after the 3rd write (count 3).
  - o_almostfull rises after the 5th write (count 5).
- Write 8 words with no reads -> o_full=1 and o_ready_s=0. A 9th write with i_valid_s=1 is dropped, count stays 8, and data order is unchanged on readout.
- Drain with i_ready_m=1:
  - Words emerge in write order, one per cycle.
  - o_full clears after the first read.
  - o_empty=1 after 8 reads, and o_dataout returns to 0.
- Continuous simultaneous write and read at count 4:
  - Count stays 4 and data stays in order.
  - Run for more than 16 cycles so both pointers wrap.
- Assert i_rst_n low mid-stream at count 6 -> flags return immediately (asynchronously) to reset values. After release, new writes read back correctly with no stale data.

Source files
------------

// File: rtl/sync_fifo_mem.sv
// Storage for sync_fifo: dual-port array, synchronous write and combinational read.
// Zero-cycle read latency. No backpressure here; the parent gates every write.
module sync_fifo_mem #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately left unreset; occupancy tracking makes stale entries invisible.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both sides and occupancy flags.
// Write-to-head latency 1 cycle; writes are refused while full, even when a read happens that cycle.
module sync_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid_s,
    input  logic                  i_ready_m,
    input  logic [WIDTH-1:0]      i_almostempty_lvl,
    input  logic [WIDTH-1:0]      i_almostfull_lvl,
    input  logic [DATA_WIDTH-1:0] i_datain,
    output logic                  o_almostfull,
    output logic                  o_full,
    output logic                  o_ready_s,
    output logic                  o_valid_m,
    output logic                  o_almostempty,
    output logic                  o_empty,
    output logic [DATA_WIDTH-1:0] o_dataout
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [WIDTH-1:0]      count_ext;
    logic [DATA_WIDTH-1:0] head_dat;
    logic                  wr_en;
    logic                  rd_en;

    assign wr_en = i_valid_s && o_ready_s;
    assign rd_en = o_valid_m && i_ready_m;

    // Depth is a power of two, so pointer wrap is just natural overflow.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_en && !rd_en) begin
                count <= count + CNT_W'(1);
            end else if (rd_en && !wr_en) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    sync_fifo_mem #(
        .DEPTH      (FIFO_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .i_clk   (i_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (i_datain),
        .rd_addr (rd_ptr),
        .rd_data (head_dat)
    );

    assign count_ext = WIDTH'(count);

    assign o_empty       = (count == '0);
    assign o_full        = (count == CNT_W'(FIFO_DEPTH));
    assign o_ready_s     = !o_full;
    assign o_valid_m     = !o_empty;
    assign o_almostempty = (count_ext <= i_almostempty_lvl);
    assign o_almostfull  = (count_ext >= i_almostfull_lvl);
    // Force zero when empty so unreset storage never leaks onto the bus.
    assign o_dataout     = o_empty ? '0 : head_dat;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo: reset, fill, overflow, drain, steady flow, mid-stream reset.
module tb_sync_fifo;

    localparam int DEPTH = 8;
    localparam int DW    = 32;
    localparam int LW    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_s;
    logic          ready_m;
    logic [LW-1:0] ae_lvl;
    logic [LW-1:0] af_lvl;
    logic [DW-1:0] datain;
    logic          almostfull;
    logic          full;
    logic          ready_s;
    logic          valid_m;
    logic          almostempty;
    logic          empty;
    logic [DW-1:0] dataout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo #(
        .FIFO_DEPTH (DEPTH),
        .DATA_WIDTH (DW),
        .WIDTH      (LW)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_valid_s         (valid_s),
        .i_ready_m         (ready_m),
        .i_almostempty_lvl (ae_lvl),
        .i_almostfull_lvl  (af_lvl),
        .i_datain          (datain),
        .o_almostfull      (almostfull),
        .o_full            (full),
        .o_ready_s         (ready_s),
        .o_valid_m         (valid_m),
        .o_almostempty     (almostempty),
        .o_empty           (empty),
        .o_dataout         (dataout)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] word(input int k);
        return 32'hC0DE_0000 + 32'(k) * 32'h0001_0011;
    endfunction

    task automatic check_reset_flags(input string tag);
        check({tag, "_empty"},   64'(empty),       64'd1);
        check({tag, "_valid"},   64'(valid_m),     64'd0);
        check({tag, "_full"},    64'(full),        64'd0);
        check({tag, "_ready"},   64'(ready_s),     64'd1);
        check({tag, "_aempty"},  64'(almostempty), 64'd1);
        check({tag, "_afull"},   64'(almostfull),  64'd0);
        check({tag, "_dataout"}, 64'(dataout),     64'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        valid_s = 1'b0;
        ready_m = 1'b0;
        ae_lvl  = 8'd2;
        af_lvl  = 8'd5;
        datain  = '0;

        repeat (2) @(negedge clk);
        af_lvl = 8'd0;
        #1;
        check("rst_afull_lvl0", 64'(almostfull), 64'd1);
        af_lvl = 8'd5;
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_flags("rst");

        // Fill with no reads; flags follow count after each edge.
        for (int k = 0; k < DEPTH; k++) begin
            valid_s = 1'b1;
            datain  = word(k);
            @(negedge clk);
            check($sformatf("fill%0d_valid", k), 64'(valid_m), 64'd1);
            check($sformatf("fill%0d_head", k), 64'(dataout), 64'(word(0)));
            check($sformatf("fill%0d_aempty", k), 64'(almostempty), 64'(k + 1 <= 2));
            check($sformatf("fill%0d_afull", k), 64'(almostfull), 64'(k + 1 >= 5));
        end
        check("full_flag", 64'(full), 64'd1);
        check("full_ready", 64'(ready_s), 64'd0);

        // Overflow attempt must be dropped.
        datain = 32'hDEAD_BEEF;
        @(negedge clk);
        check("ovf_full", 64'(full), 64'd1);
        check("ovf_head", 64'(dataout), 64'(word(0)));

        // Write+read while full: only the read happens, ready returns next cycle.
        datain  = 32'hBAD0_0001;
        ready_m = 1'b1;
        @(negedge clk);
        check("fullrw_full", 64'(full), 64'd0);
        check("fullrw_ready", 64'(ready_s), 64'd1);
        valid_s = 1'b0;

        for (int k = 1; k < DEPTH; k++) begin
            check($sformatf("drain%0d_data", k), 64'(dataout), 64'(word(k)));
            @(negedge clk);
        end
        check("drained_empty", 64'(empty), 64'd1);
        check("drained_valid", 64'(valid_m), 64'd0);
        check("drained_data", 64'(dataout), 64'd0);

        // Empty read ignored; prime to count 4.
        ready_m = 1'b0;
        valid_s = 1'b1;
        for (int k = 0; k < 4; k++) begin
            datain = word(16 + k);
            @(negedge clk);
        end

        // Steady flow at count 4, long enough for both pointers to wrap twice.
        ready_m = 1'b1;
        for (int i = 0; i < 20; i++) begin
            datain = word(20 + i);
            check($sformatf("flow%0d_data", i), 64'(dataout), 64'(word(16 + i)));
            @(negedge clk);
            check($sformatf("flow%0d_aempty", i), 64'(almostempty), 64'd0);
        end
        check("flow_afull", 64'(almostfull), 64'd0);
        check("flow_head", 64'(dataout), 64'(word(36)));

        // Raise to count 6, then reset asynchronously between edges.
        ready_m = 1'b0;
        datain  = word(40);
        @(negedge clk);
        datain  = word(41);
        @(negedge clk);
        valid_s = 1'b0;
        check("cnt6_afull", 64'(almostfull), 64'd1);
        check("cnt6_head", 64'(dataout), 64'(word(36)));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_flags("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_empty", 64'(empty), 64'd1);

        valid_s = 1'b1;
        datain  = word(50);
        @(negedge clk);
        datain  = word(51);
        @(negedge clk);
        valid_s = 1'b0;
        ready_m = 1'b1;
        check("postrst_d0", 64'(dataout), 64'(word(50)));
        @(negedge clk);
        check("postrst_d1", 64'(dataout), 64'(word(51)));
        @(negedge clk);
        check("postrst_empty2", 64'(empty), 64'd1);
        check("postrst_data0", 64'(dataout), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
